// File: rtl/inputs_pkg.sv
// Shared constants and read-word packing for the switch/button input peripheral.
package inputs_pkg;

    localparam int N_SW  = 16;
    localparam int N_BTN = 4;

    localparam logic SEL_SWITCHES = 1'b0;
    localparam logic SEL_BUTTONS  = 1'b1;

    // Bit offsets inside the button read word
    localparam int EVT_LSB = 0;
    localparam int LVL_LSB = 4;

    function automatic logic [31:0] button_word(input logic [N_BTN-1:0] levels,
                                                input logic [N_BTN-1:0] events);
        logic [31:0] word;
        word = '0;
        word[LVL_LSB +: N_BTN] = levels;
        word[EVT_LSB +: N_BTN] = events;
        return word;
    endfunction

    function automatic logic [31:0] switch_word(input logic [N_SW-1:0] levels);
        logic [31:0] word;
        word = '0;
        word[N_SW-1:0] = levels;
        return word;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchronizer, optional debounce counter, stable register.
// Debounce counter is present only when INPUTS_DEBOUNCE_EN is defined.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("debounce_bit: DEBOUNCE_CYCLES must be at least 2");
    end

    logic sync_1;
    logic sync_2;

    // NOTE: flop-to-flop chains must use non-blocking assignments, or sync_2
    // would see this edge's sync_1 and the chain collapses to one stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

`ifdef INPUTS_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             stable_q;

    // Any return to the stable value restarts the count, so short glitches die here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            stable_q <= 1'b0;
        end else if (sync_2 == stable_q) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count    <= '0;
            stable_q <= sync_2;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync_2;
`endif

endmodule

// File: rtl/inputs_control.sv
// Memory-mapped switch/button input peripheral with press-event latching and read-to-clear.
// Optional debounce is enabled with the INPUTS_DEBOUNCE_EN macro.
module inputs_control
    import inputs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             re_inputs,
    input  logic             sel,
    output logic [31:0]      read_data,
    output logic             btn_pending
);

    logic [N_SW-1:0]  sw_stable;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_prev;
    logic [N_BTN-1:0] btn_events;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] events_next;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw    (btn_raw[i]),
            .stable (btn_stable[i])
        );
    end

    assign btn_rise = btn_stable & ~btn_prev;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        events_next = btn_events;
        if (re_inputs && sel == SEL_BUTTONS) begin
            events_next = '0;
        end
        // A press landing on the clearing edge must survive the clear
        events_next = events_next | btn_rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev   <= '0;
            btn_events <= '0;
        end else begin
            btn_prev   <= btn_stable;
            btn_events <= events_next;
        end
    end

    always_comb begin
        read_data = '0;
        if (sel == SEL_BUTTONS) begin
            read_data = button_word(btn_stable, btn_events);
        end else begin
            read_data = switch_word(sw_stable);
        end
    end

    assign btn_pending = |btn_events;

endmodule

// File: tb/tb_inputs_control.sv
// Scoreboard bench for inputs_control; expectations adapt to whether INPUTS_DEBOUNCE_EN is defined.
module tb_inputs_control;
    import inputs_pkg::*;

    localparam int DC = 4;
`ifdef INPUTS_DEBOUNCE_EN
    localparam int LAT     = DC + 2;
    localparam int GLITCH_W = 3;
    localparam bit GLITCH_PASSES = 1'b0;
`else
    localparam int LAT     = 2;
    localparam int GLITCH_W = 1;
    localparam bit GLITCH_PASSES = 1'b1;
`endif

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] data;
        logic        pend;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_SW-1:0]  sw_raw = '0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic             re_inputs = 1'b0;
    logic             sel = 1'b0;
    logic [31:0]      read_data;
    logic             btn_pending;

    inputs_control #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .btn_raw     (btn_raw),
        .re_inputs   (re_inputs),
        .sel         (sel),
        .read_data   (read_data),
        .btn_pending (btn_pending)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string name, input int cyc,
                                input logic [31:0] data, input logic pend);
        exp_t e;
        e.name = name;
        e.cyc  = cyc;
        e.data = data;
        e.pend = pend;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        reset = 1'b0; sw_raw = 16'hA5C3; btn_raw = '0; re_inputs = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = (k == 1) ? SEL_BUTTONS : SEL_SWITCHES;
            sb.push_back(mk("reset_hold", k, 32'h0, 1'b0));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
        sel = SEL_SWITCHES;
        reset = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            sb.push_back(mk("release_latency", k, (k >= LAT) ? 32'h0000A5C3 : 32'h0, 1'b0));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
    endtask

    task automatic test_glitch;
        exp_t        e;
        logic [31:0] exp_data;
        sel = SEL_SWITCHES;
        for (int k = 0; k < LAT + 5; k++) begin
            sw_raw = (k < GLITCH_W) ? 16'hA5C7 : 16'hA5C3;
            // sync_2 after this edge holds what was driven one iteration earlier
            exp_data = (GLITCH_PASSES && k >= 1 && k - 1 < GLITCH_W) ? 32'h0000A5C7 : 32'h0000A5C3;
            sb.push_back(mk("glitch", k, exp_data, 1'b0));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
    endtask

    task automatic test_button_clear;
        exp_t        e;
        logic [31:0] exp_data;
        sel = SEL_BUTTONS;
        btn_raw = 4'b0100;
        for (int k = 1; k <= LAT + 2; k++) begin
            exp_data = ((k >= LAT) ? 32'h40 : 32'h0) | ((k >= LAT + 1) ? 32'h04 : 32'h0);
            sb.push_back(mk("press", k, exp_data, k >= LAT + 1));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
        re_inputs = 1'b1;
        sb.push_back(mk("read_cycle_preclear", 0, 32'h44, 1'b1));
        #1;
        e = sb.pop_front();
        n_total++;
        if (read_data !== e.data || btn_pending !== e.pend)
            $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                     e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
        else n_pass++;
        sb.push_back(mk("after_clear", 1, 32'h40, 1'b0));
        tick();
        re_inputs = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (read_data !== e.data || btn_pending !== e.pend)
            $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                     e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
        else n_pass++;
        btn_raw = '0;
        for (int k = 1; k <= LAT + 1; k++) begin
            sb.push_back(mk("release_no_event", k, (k >= LAT) ? 32'h0 : 32'h40, 1'b0));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
    endtask

    task automatic test_clear_collision;
        exp_t        e;
        logic [31:0] exp_data;
        sel = SEL_BUTTONS;
        btn_raw = 4'b0010;
        for (int k = 1; k <= LAT + 1; k++) begin
            re_inputs = (k == LAT + 1);
            exp_data = ((k >= LAT) ? 32'h20 : 32'h0) | ((k >= LAT + 1) ? 32'h02 : 32'h0);
            sb.push_back(mk("collide", k, exp_data, k >= LAT + 1));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
        // Switch-word read must not touch the events
        sel = SEL_SWITCHES; re_inputs = 1'b1;
        sb.push_back(mk("sw_read_no_side_effect", 0, 32'h0000A5C3, 1'b1));
        tick();
        e = sb.pop_front();
        n_total++;
        if (read_data !== e.data || btn_pending !== e.pend)
            $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                     e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
        else n_pass++;
        sel = SEL_BUTTONS; re_inputs = 1'b0;
        sb.push_back(mk("event_retained", 1, 32'h22, 1'b1));
        tick();
        e = sb.pop_front();
        n_total++;
        if (read_data !== e.data || btn_pending !== e.pend)
            $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                     e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
        else n_pass++;
        re_inputs = 1'b1;
        sb.push_back(mk("final_clear", 2, 32'h20, 1'b0));
        tick();
        re_inputs = 1'b0;
        btn_raw = '0;
        e = sb.pop_front();
        n_total++;
        if (read_data !== e.data || btn_pending !== e.pend)
            $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                     e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
        else n_pass++;
    endtask

    task automatic test_reset_mid_count;
        exp_t e;
        sel = SEL_SWITCHES;
        sw_raw = 16'hA5C2;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back(mk("pre_reset", k, (k >= LAT) ? 32'h0000A5C2 : 32'h0000A5C3, 1'b0));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
        #2;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sel = (k == 0) ? SEL_SWITCHES : SEL_BUTTONS;
            sb.push_back(mk("async_reset", k, 32'h0, 1'b0));
            #1;
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
        sel = SEL_SWITCHES;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            sb.push_back(mk("post_reset_latency", k, (k >= LAT) ? 32'h0000A5C2 : 32'h0, 1'b0));
            tick();
            e = sb.pop_front();
            n_total++;
            if (read_data !== e.data || btn_pending !== e.pend)
                $display("FAIL %s[%0d]: read_data=%h btn_pending=%b, expected %h/%b",
                         e.name, e.cyc, read_data, btn_pending, e.data, e.pend);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_button_clear();
        test_clear_collision();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inputs_control.md
# inputs_control

Memory-mapped input peripheral, the read-side counterpart of the LED output register. It samples 16 slide switches and 4 push buttons and synchronizes them into the `clk` domain. It debounces them and latches button press events. The CPU reads either the debounced levels or the pending press flags through a 32-bit data word, and an interrupt-style pending line stays asserted while any press is unread.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: number of consecutive cycles a synchronized input must differ from its stable value before the stable value changes. Must be ≥ 2.
- `clk` input 1: single system clock. All state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserts immediately, releases on `clk`.
- `sw_raw` input 16: raw switch pins, asynchronous to `clk`.
- `btn_raw` input 4: raw button pins, asynchronous to `clk`, 1 = pressed.
- `re_inputs` input 1: CPU load strobe for this peripheral, one cycle per access.
- `sel` input 1: 0 = switch level word, 1 = button event word.
- `read_data` output 32: read word.
  - `sel`=0: {16'b0, sw_stable}.
  - `sel`=1: {24'b0, btn_stable, btn_events}.
- `btn_pending` output 1: OR of `btn_events`.

## Operation
- Per input bit, the datapath is a 2-FF synchronizer, then a debounce counter, then a stable register.
- Debounce, per bit:
  - If synced == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES−1, stable takes the synced value and the counter clears.
  - The counter width is $clog2(DEBOUNCE_CYCLES). It never wraps.
- Glitch rule: a pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches stable. Any return to the stable value restarts the count from 0.
- Event detect: a 0→1 transition of `btn_stable[i]` sets `btn_events[i]` on the next edge. A 1→0 transition sets nothing.
- Read-to-clear: `re_inputs`=1 with `sel`=1 clears all `btn_events` bits on that edge.
  - `read_data` during the read cycle still shows the pre-clear value.
- Simultaneous clear and new press of the same bit: the set wins, so the bit reads 1 afterwards. A press is never lost.
- `re_inputs` with `sel`=0 has no side effects.
- `read_data` is combinational from registered state and valid every cycle regardless of `re_inputs`.
- Reset values:
  - All synchronizer flops, counters, `sw_stable`, `btn_stable` and `btn_events` are 0.
  - `read_data` = 0 and `btn_pending` = 0.
  - Reset mid-count discards the partial count.

## Timing
- Raw to synced: 2 edges.
- With debounce, raw steady change to stable: DEBOUNCE_CYCLES + 2 edges.
- Stable rising to event set: +1 edge.
- `btn_pending` follows `btn_events` combinationally, with no extra latency.
- Clear takes effect on the edge that samples `re_inputs`. Event bits read 0 from the following cycle.
- No handshake back-pressure: reads complete in the same cycle.

## Configuration
- `INPUTS_DEBOUNCE_EN` defined: debounce counters are present as described.
- `INPUTS_DEBOUNCE_EN` undefined:
  - Counters are removed, stable = synced, and `DEBOUNCE_CYCLES` is ignored.
  - Latency from raw to stable is 2 edges. Event detect and read-to-clear are unchanged.

## Structure
- Package `inputs_pkg`:
  - N_SW = 16 and N_BTN = 4.
  - SEL_SWITCHES = 1'b0 and SEL_BUTTONS = 1'b1.
  - Read-word field offsets: events at [3:0], button levels at [7:4].
- Sub-module `debounce_bit`:
  - Holds the synchronizer, counter and stable register for one bit.
  - Takes the `DEBOUNCE_CYCLES` parameter and honours the macro.
  - Instantiated 20 times via generate.

## Test plan
Run with DEBOUNCE_CYCLES = 4 and `INPUTS_DEBOUNCE_EN` defined unless noted.

1. Reset and steady level:
   - During reset, `read_data` = 0 and `btn_pending` = 0.
   - Release with `sw_raw` = 16'hA5C3. `read_data` (`sel`=0) = 32'h0000A5C3 exactly 6 edges after release, and 0 before.
2. Glitch rejection: `sw_raw[0]` pulses high for 3 cycles then returns low. `read_data[0]` stays 0 throughout.
3. Button press and read-to-clear:
   - `btn_raw[2]` is held high. `btn_pending` = 1 after 7 edges. `sel`=1 reads 32'h44.
   - A `re_inputs` pulse makes the next-cycle read 32'h40 and `btn_pending` = 0.
4. Clear collides with set: `re_inputs` with `sel`=1 lands on the same edge that sets `btn_events[1]`. Afterwards bit 1 = 1 and `btn_pending` = 1.
5. Async reset mid-count: assert `reset` low while a switch counter is at 2. All outputs go to 0 immediately, and a full 6-edge latency is required after release.
6. `INPUTS_DEBOUNCE_EN` undefined: `sw_raw` = 16'h0001 appears on `read_data` after 2 edges, and a 1-cycle glitch propagates through.
